// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the programmable clock divider: channel FSM
// encoding, minimum legal divisor and the divisor clamp.
package clk_gen_pkg;

    localparam int unsigned DIV_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ch_state_e;

    // Divisors below DIV_MIN cannot produce a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < DIV_MIN) ? 32'(DIV_MIN) : div;
    endfunction

endpackage

// File: rtl/clk_prog_div_ch.sv
// One divider channel: IDLE/RUN/DRAIN sequencer, period counter, pending/active
// divisor pair. Lock counter present only with CLK_PROG_DIV_LOCK_EN defined.
module clk_prog_div_ch
    import clk_gen_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned DIV_INIT = 2,
    parameter int unsigned LOCK_CNT = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ch_en_i,
    input  logic [DW-1:0] div_val_i,
    input  logic          div_load_i,
    output logic          outclk_o,
    output logic          outclkn_o,
    output logic          clk_en_pulse_o,
    output logic          locked_o
);

    localparam logic [DW-1:0] DIV_RST = DW'(clamp_div(32'(DIV_INIT)));

    ch_state_e     state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] n_q, n_d;
    logic [DW-1:0] p_q, p_d;
    logic [DW-1:0] h_d;
    logic          wrap_c;
    logic          outclk_d, pulse_d, locked_d;
    logic          outclk_q, outclkn_q, pulse_q, locked_q;

    assign wrap_c = (state_q != ST_IDLE) && (cnt_q == n_q - DW'(1));

    // Next state; a load in the wrap cycle is already visible through p_d.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        p_d     = div_load_i ? DW'(clamp_div(32'(div_val_i))) : p_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ch_en_i) begin
                    state_d = ST_RUN;
                    n_d     = p_d;
                end
            end
            ST_RUN, ST_DRAIN: begin
                cnt_d = wrap_c ? '0 : cnt_q + DW'(1);
                if (wrap_c) begin
                    n_d = p_d;
                end
                if (ch_en_i) begin
                    state_d = ST_RUN;
                end else if (state_q == ST_RUN) begin
                    state_d = ST_DRAIN;
                end else if (wrap_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // High for ceil(N/2) cycles at the start of each period.
    assign h_d      = n_d - (n_d >> 1);
    assign outclk_d = (state_d != ST_IDLE) && (cnt_d < h_d);
    assign pulse_d  = (state_d != ST_IDLE) && (cnt_d == '0);

`ifdef CLK_PROG_DIV_LOCK_EN
    localparam int unsigned LW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

    logic [LW-1:0] lock_q, lock_d;

    // Counts completed RUN periods at an unchanged divisor, saturating.
    always_comb begin
        lock_d = lock_q;
        if ((state_q != ST_RUN) || (state_d != ST_RUN)) begin
            lock_d = '0;
        end else if (wrap_c) begin
            if (n_d != n_q) begin
                lock_d = '0;
            end else if (lock_q != LW'(LOCK_CNT)) begin
                lock_d = lock_q + LW'(1);
            end
        end
    end

    assign locked_d = (lock_d == LW'(LOCK_CNT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_lock_cnt;

    assign unused_lock_cnt = ^32'(LOCK_CNT);
    assign locked_d        = (state_d == ST_RUN);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            n_q       <= DIV_RST;
            p_q       <= DIV_RST;
            outclk_q  <= 1'b0;
            outclkn_q <= 1'b1;
            pulse_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            p_q       <= p_d;
            outclk_q  <= outclk_d;
            outclkn_q <= ~outclk_d;
            pulse_q   <= pulse_d;
            locked_q  <= locked_d;
        end
    end

    assign outclk_o       = outclk_q;
    assign outclkn_o      = outclkn_q;
    assign clk_en_pulse_o = pulse_q;
    assign locked_o       = locked_q;

endmodule

// File: rtl/clk_prog_division.sv
// Multi-channel programmable clock divider; CH independent channels.
// Optional lock counter enabled by defining CLK_PROG_DIV_LOCK_EN.
module clk_prog_division
    import clk_gen_pkg::*;
#(
    parameter int unsigned CH       = 2,
    parameter int unsigned DW       = 8,
    parameter int unsigned DIV_INIT = 2,
    parameter int unsigned LOCK_CNT = 15
) (
    input  logic             inclk,
    input  logic             rst,
    input  logic [CH-1:0]    ch_en,
    input  logic [CH*DW-1:0] div_val,
    input  logic [CH-1:0]    div_load,
    output logic [CH-1:0]    outclk,
    output logic [CH-1:0]    outclkn,
    output logic [CH-1:0]    clk_en_pulse,
    output logic [CH-1:0]    locked
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        clk_prog_div_ch #(
            .DW       (DW),
            .DIV_INIT (DIV_INIT),
            .LOCK_CNT (LOCK_CNT)
        ) u_ch (
            .clk_i          (inclk),
            .rst_i          (rst),
            .ch_en_i        (ch_en[i]),
            .div_val_i      (div_val[i*DW +: DW]),
            .div_load_i     (div_load[i]),
            .outclk_o       (outclk[i]),
            .outclkn_o      (outclkn[i]),
            .clk_en_pulse_o (clk_en_pulse[i]),
            .locked_o       (locked[i])
        );
    end

endmodule

// File: tb/tb_clk_prog_division.sv
// Scoreboard bench for clk_prog_division: a per-channel reference model pushes
// the expected outputs for each driven cycle; they are popped on the next negedge.
module tb_clk_prog_division;

    localparam int unsigned CH       = 2;
    localparam int unsigned DW       = 8;
    localparam int unsigned LOCK_CNT = 15;

    logic             inclk = 1'b0;
    logic             rst;
    logic [CH-1:0]    ch_en;
    logic [CH*DW-1:0] div_val;
    logic [CH-1:0]    div_load;
    logic [CH-1:0]    outclk;
    logic [CH-1:0]    outclkn;
    logic [CH-1:0]    clk_en_pulse;
    logic [CH-1:0]    locked;

    clk_prog_division #(
        .CH       (CH),
        .DW       (DW),
        .DIV_INIT (2),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .inclk        (inclk),
        .rst          (rst),
        .ch_en        (ch_en),
        .div_val      (div_val),
        .div_load     (div_load),
        .outclk       (outclk),
        .outclkn      (outclkn),
        .clk_en_pulse (clk_en_pulse),
        .locked       (locked)
    );

    always #5 inclk = ~inclk;

    typedef struct {
        logic [1:0] oc;
        logic [1:0] pl;
        logic [1:0] lk;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: st 0=idle 1=run 2=drain, pos = position in period.
    int m_st[CH];
    int m_pos[CH];
    int m_n[CH];
    int m_p[CH];
    int m_lk[CH];
    int pulse_cnt[CH];
    int hi_cnt[CH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_ch(input int c, input logic r, input logic en, input logic ld, input int v);
        int pnew;
        int old_st;
        int old_n;
        bit wr;
        if (r) begin
            m_st[c] = 0; m_pos[c] = 0; m_n[c] = 2; m_p[c] = 2; m_lk[c] = 0;
            return;
        end
        pnew   = ld ? ((v < 2) ? 2 : v) : m_p[c];
        old_st = m_st[c];
        old_n  = m_n[c];
        wr     = (old_st != 0) && (m_pos[c] == m_n[c] - 1);
        if (old_st == 0) begin
            m_pos[c] = 0;
            if (en) begin
                m_st[c] = 1;
                m_n[c]  = pnew;
            end
        end else begin
            m_pos[c] = wr ? 0 : m_pos[c] + 1;
            if (wr) m_n[c] = pnew;
            if (en) m_st[c] = 1;
            else if (old_st == 1) m_st[c] = 2;
            else if (wr) m_st[c] = 0;
        end
        if (old_st == 1 && m_st[c] == 1) begin
            if (wr) m_lk[c] = (m_n[c] != old_n) ? 0 : ((m_lk[c] < int'(LOCK_CNT)) ? m_lk[c] + 1 : m_lk[c]);
        end else begin
            m_lk[c] = 0;
        end
        m_p[c] = pnew;
    endtask

    task automatic sample_and_check();
        exp_t       e;
        logic [1:0] ocn_e;
        if (sb_q.size() == 0) return;
        e     = sb_q.pop_front();
        ocn_e = ~e.oc;
        check_eq("outclk", 32'(outclk), 32'(e.oc));
        check_eq("outclkn", 32'(outclkn), 32'(ocn_e));
        check_eq("clk_en_pulse", 32'(clk_en_pulse), 32'(e.pl));
        check_eq("locked", 32'(locked), 32'(e.lk));
        for (int c = 0; c < int'(CH); c++) begin
            pulse_cnt[c] += int'(clk_en_pulse[c]);
            hi_cnt[c]    += int'(outclk[c]);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] en, input logic [1:0] ld,
                        input logic [7:0] v0, input logic [7:0] v1);
        exp_t e;
        @(negedge inclk);
        sample_and_check();
        rst      = r;
        ch_en    = en;
        div_load = ld;
        div_val  = {v1, v0};
        model_ch(0, r, en[0], ld[0], int'(v0));
        model_ch(1, r, en[1], ld[1], int'(v1));
        for (int c = 0; c < int'(CH); c++) begin
            e.oc[c] = (m_st[c] != 0) && (m_pos[c] < (m_n[c] + 1) / 2);
            e.pl[c] = (m_st[c] != 0) && (m_pos[c] == 0);
`ifdef CLK_PROG_DIV_LOCK_EN
            e.lk[c] = (m_lk[c] == int'(LOCK_CNT));
`else
            e.lk[c] = (m_st[c] == 1);
`endif
        end
        sb_q.push_back(e);
        @(posedge inclk);
    endtask

    task automatic clear_counts();
        for (int c = 0; c < int'(CH); c++) begin
            pulse_cnt[c] = 0;
            hi_cnt[c]    = 0;
        end
    endtask

    // Advance until channel c is active at period position pos with divisor n.
    task automatic run_until(input int c, input int pos, input int n, input logic [1:0] en);
        bit found = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (m_st[c] != 0 && m_pos[c] == pos && m_n[c] == n) begin
                found = 1'b1;
                break;
            end
            step(1'b0, en, 2'b00, 8'd0, 8'd0);
        end
        check_eq("wait_phase", 32'(found), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        ch_en    = '0;
        div_load = '0;
        div_val  = '0;

        repeat (3) step(1'b1, 2'b00, 2'b00, 8'd0, 8'd0);

        // Default divisor 2 from reset.
        repeat (40) step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        repeat (4) step(1'b0, 2'b00, 2'b00, 8'd0, 8'd0);

        // N=5 loaded while idle.
        step(1'b0, 2'b00, 2'b01, 8'd5, 8'd0);
        step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        clear_counts();
        repeat (20) step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        check_eq("n5_pulses", 32'(pulse_cnt[0]), 32'd4);
        check_eq("n5_high", 32'(hi_cnt[0]), 32'd12);

        // N=4 to lock, then reload 7 at cnt=1.
        step(1'b0, 2'b01, 2'b01, 8'd4, 8'd0);
        repeat (70) step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        run_until(0, 1, 4, 2'b01);
        step(1'b0, 2'b01, 2'b01, 8'd7, 8'd0);
        run_until(0, 0, 7, 2'b01);
        clear_counts();
        repeat (7) step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        check_eq("n7_high", 32'(hi_cnt[0]), 32'd4);
        check_eq("n7_pulses", 32'(pulse_cnt[0]), 32'd1);
        repeat (110) step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);

        // N=6: drain to idle, then drain with re-enable at cnt=3.
        step(1'b0, 2'b01, 2'b01, 8'd6, 8'd0);
        repeat (20) step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        run_until(0, 1, 6, 2'b01);
        repeat (9) step(1'b0, 2'b00, 2'b00, 8'd0, 8'd0);
        step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        repeat (13) step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        run_until(0, 1, 6, 2'b01);
        repeat (2) step(1'b0, 2'b00, 2'b00, 8'd0, 8'd0);
        step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        clear_counts();
        repeat (12) step(1'b0, 2'b01, 2'b00, 8'd0, 8'd0);
        check_eq("n6_reen_pulses", 32'(pulse_cnt[0]), 32'd2);
        check_eq("n6_reen_high", 32'(hi_cnt[0]), 32'd6);
        repeat (10) step(1'b0, 2'b00, 2'b00, 8'd0, 8'd0);

        // Clamp of 0 and 1, full-range 255 on channel 1.
        step(1'b0, 2'b00, 2'b10, 8'd0, 8'd0);
        step(1'b0, 2'b10, 2'b00, 8'd0, 8'd0);
        clear_counts();
        repeat (10) step(1'b0, 2'b10, 2'b00, 8'd0, 8'd0);
        check_eq("clamp0_pulses", 32'(pulse_cnt[1]), 32'd5);
        check_eq("clamp0_high", 32'(hi_cnt[1]), 32'd5);
        step(1'b0, 2'b10, 2'b10, 8'd0, 8'd1);
        repeat (10) step(1'b0, 2'b10, 2'b00, 8'd0, 8'd0);
        step(1'b0, 2'b10, 2'b10, 8'd0, 8'd255);
        run_until(1, 0, 255, 2'b10);
        clear_counts();
        repeat (255) step(1'b0, 2'b10, 2'b00, 8'd0, 8'd0);
        check_eq("n255_high", 32'(hi_cnt[1]), 32'd128);
        check_eq("n255_pulses", 32'(pulse_cnt[1]), 32'd1);

        // Independent channels, then reset at cnt=3 of N=9.
        step(1'b0, 2'b10, 2'b11, 8'd9, 8'd3);
        repeat (20) step(1'b0, 2'b11, 2'b00, 8'd0, 8'd0);
        repeat (30) step(1'b0, 2'b11, 2'b01, 8'($urandom_range(0, 20)), 8'd0);
        step(1'b0, 2'b11, 2'b01, 8'd9, 8'd0);
        run_until(0, 3, 9, 2'b11);
        repeat (2) step(1'b1, 2'b11, 2'b00, 8'd0, 8'd0);
        repeat (20) step(1'b0, 2'b11, 2'b00, 8'd0, 8'd0);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            logic [1:0] en_r;
            logic [1:0] ld_r;
            en_r = 2'($urandom);
            ld_r = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            step(1'b0, en_r, ld_r, 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)));
        end

        @(negedge inclk);
        sample_and_check();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
